uart_rx_ctrl: RTL and testbench

UART receive sequencer that oversamples the serial line, frames start/data/parity/stop bits and delivers the received byte. It owns the receive parity checker: it drives that checker's reset, Compute and Check strobes and its data input, so the checker sees exactly the bits the sequencer samples. It sits between the pin-level RxD and the UART register interface, which reads RxData and acknowledges with RxRead.

---
 rtl/uart_rx_ctrl_if.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 146 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Register-side bundle of the UART receiver: received word, status flags, read strobe.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] RxData;
  logic                 RxReady;
  logic                 RxFramingErr;
  logic                 RxParErr;
  logic                 RxOverrun;
  logic                 RxRead;

  modport master (
    output RxData,
    output RxReady,
    output RxFramingErr,
    output RxParErr,
    output RxOverrun,
    input  RxRead
  );

  modport slave (
    input  RxData,
    input  RxReady,
    input  RxFramingErr,
    input  RxParErr,
    input  RxOverrun,
    output RxRead
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receive sequencer driving an external parity checker.
// Define RX_PARITY_EN to add the parity bit and the checker strobes.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic BaudTick,
  input  logic RxD,
  input  logic RxParityErr,
  output logic RxDSync,
  output logic ParityRst,
  output logic Compute,
  output logic Check,
  uart_rx_ctrl_if.master rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

`ifdef RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t               state;
  state_t               state_nx;
  logic                 rxd_meta;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample;
  logic                 done;
  logic                 par_err;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rxd_meta <= 1'b1;
      RxDSync  <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      RxDSync  <= rxd_meta;
    end
  end

  // Counter restarts at the start-bit midpoint, so later bits are
  // sampled a full bit period on, landing again at mid-bit.
  always_comb begin
    sample = 1'b0;
    unique case (state)
      START:              sample = BaudTick && (tick_cnt == MID);
      DATA, PARITY, STOP: sample = BaudTick && (tick_cnt == LAST);
      default:            sample = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!RxDSync) state_nx = START;
      START:   if (sample) state_nx = RxDSync ? IDLE : DATA;
      DATA:    if (sample && (bit_cnt == BLAST)) state_nx = AFTER_DATA;
      PARITY:  if (sample) state_nx = STOP;
      STOP:    if (sample) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        tick_cnt <= '0;
      else if (BaudTick && (state != IDLE))
        tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
      if (state != DATA)
        bit_cnt <= '0;
      else if (sample)
        bit_cnt <= bit_cnt + 1'b1;
      if ((state == DATA) && sample)
        shreg <= {RxDSync, shreg[DATA_BITS-1:1]};
    end
  end

  always_comb begin
    ParityRst = Reset;
    Compute   = 1'b0;
    Check     = 1'b0;
`ifdef RX_PARITY_EN
    if ((state == START) && sample && !RxDSync) ParityRst = 1'b1;
    if ((state == DATA) && sample)   Compute = 1'b1;
    if ((state == PARITY) && sample) Check   = 1'b1;
`endif
  end

`ifdef RX_PARITY_EN
  assign par_err = RxParityErr;
`else
  logic unused_parity_err;
  assign unused_parity_err = RxParityErr;
  assign par_err = 1'b0;
`endif

  assign done = (state == STOP) && sample;

  // Completion beats a same-cycle read: the new word stays pending.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx.RxData       <= '0;
      rx.RxReady      <= 1'b0;
      rx.RxFramingErr <= 1'b0;
      rx.RxParErr     <= 1'b0;
      rx.RxOverrun    <= 1'b0;
    end else if (done) begin
      rx.RxData       <= shreg;
      rx.RxReady      <= 1'b1;
      rx.RxFramingErr <= ~RxDSync;
      rx.RxParErr     <= par_err;
      rx.RxOverrun    <= (rx.RxReady | rx.RxOverrun) & ~rx.RxRead;
    end else if (rx.RxRead) begin
      rx.RxReady      <= 1'b0;
      rx.RxFramingErr <= 1'b0;
      rx.RxParErr     <= 1'b0;
      rx.RxOverrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int DB  = 8;
  localparam int OS  = 16;
`ifdef RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic BaudTick = 1'b0;
  logic RxD = 1'b1;
  logic RxParityErr;
  logic RxDSync, ParityRst, Compute, Check;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) rxif();

  uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BaudTick    (BaudTick),
    .RxD         (RxD),
    .RxParityErr (RxParityErr),
    .RxDSync     (RxDSync),
    .ParityRst   (ParityRst),
    .Compute     (Compute),
    .Check       (Check),
    .rx          (rxif)
  );

  always #5 Clock = ~Clock;

  initial begin
    forever begin
      repeat (3) @(negedge Clock);
      BaudTick = 1'b1;
      @(negedge Clock);
      BaudTick = 1'b0;
    end
  end

  // Even-parity checker the sequencer strobes.
  logic acc, perr;
  always @(posedge Clock) begin
    if (ParityRst) begin
      acc  <= 1'b0;
      perr <= 1'b0;
    end else begin
      if (Compute) acc <= acc ^ RxDSync;
      if (Check) perr <= acc ^ RxDSync;
    end
  end
  assign RxParityErr = perr;

  int n_comp = 0, n_chk = 0, n_prst = 0, n_both = 0;
  always @(posedge Clock) begin
    if (Compute) n_comp++;
    if (Check) n_chk++;
    if (ParityRst && !Reset) n_prst++;
    if (Compute && Check) n_both++;
  end

  logic [DB-1:0] m_data = '0;
  logic m_rdy = 0, m_fe = 0, m_pe = 0, m_ov = 0;

  int checks = 0, failures = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    expect_eq({tag, ".data"}, 32'(rxif.RxData), 32'(m_data));
    expect_eq({tag, ".rdy"}, 32'(rxif.RxReady), 32'(m_rdy));
    expect_eq({tag, ".fe"}, 32'(rxif.RxFramingErr), 32'(m_fe));
    expect_eq({tag, ".pe"}, 32'(rxif.RxParErr), 32'(m_pe));
    expect_eq({tag, ".ov"}, 32'(rxif.RxOverrun), 32'(m_ov));
  endtask

  task automatic check_strobes(input string tag);
    expect_eq({tag, ".ncomp"}, 32'(n_comp), 32'(DB * PAR));
    expect_eq({tag, ".nchk"}, 32'(n_chk), 32'(PAR));
    expect_eq({tag, ".nprst"}, 32'(n_prst), 32'(PAR));
  endtask

  task automatic bit_hold(input logic b, input int ticks);
    RxD = b;
    repeat (ticks * 4) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic pb,
                            input logic sb);
    n_comp = 0;
    n_chk = 0;
    n_prst = 0;
    bit_hold(1'b0, OS);
    for (int i = 0; i < DB; i++) bit_hold(d[i], OS);
    if (PAR != 0) bit_hold(pb, OS);
    bit_hold(sb, 12);
    bit_hold(1'b1, 24);
    m_ov   = m_rdy;
    m_rdy  = 1'b1;
    m_data = d;
    m_fe   = ~sb;
    m_pe   = (PAR != 0) ? (pb ^ (^d)) : 1'b0;
  endtask

  task automatic do_read();
    rxif.RxRead = 1'b1;
    @(negedge Clock);
    rxif.RxRead = 1'b0;
    @(negedge Clock);
    m_rdy = 0;
    m_fe  = 0;
    m_pe  = 0;
    m_ov  = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DB-1:0] d;
    logic pb, sb;
    rxif.RxRead = 1'b0;
    repeat (3) @(negedge Clock);
    expect_eq("rst.prst", 32'(ParityRst), 32'd1);
    expect_eq("rst.sync", 32'(RxDSync), 32'd1);
    expect_eq("rst.comp", 32'(Compute), 32'd0);
    expect_eq("rst.chk", 32'(Check), 32'd0);
    check_out("rst");
    Reset = 1'b0;
    repeat (40) @(negedge Clock);
    expect_eq("idle.prst", 32'(ParityRst), 32'd0);

    send_frame(8'h5A, 1'b0, 1'b1);
    check_out("f5a");
    check_strobes("f5a");
    do_read();
    check_out("f5a_rd");

    send_frame(8'h5A, 1'b1, 1'b1);
    check_out("f5a_pe");
    do_read();

    n_comp = 0;
    n_prst = 0;
    bit_hold(1'b0, 4);
    bit_hold(1'b1, 24);
    expect_eq("glitch.ncomp", 32'(n_comp), 32'd0);
    expect_eq("glitch.nprst", 32'(n_prst), 32'd0);
    check_out("glitch");

    send_frame(8'hA5, 1'b0, 1'b0);
    check_out("fa5_fe");
    do_read();
    send_frame(8'h3C, 1'b0, 1'b1);
    check_out("f3c");
    check_strobes("f3c");
    do_read();

    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'hC7, 1'b1, 1'b1);
    check_out("ovr");
    do_read();
    check_out("ovr_rd");

    d = 8'h96;
    bit_hold(1'b0, OS);
    for (int i = 0; i < 4; i++) bit_hold(d[i], OS);
    RxD = d[4];
    repeat (OS * 2) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    m_data = '0;
    m_rdy = 0;
    m_fe = 0;
    m_pe = 0;
    m_ov = 0;
    check_out("midrst");
    expect_eq("midrst.prst", 32'(ParityRst), 32'd1);
    expect_eq("midrst.sync", 32'(RxDSync), 32'd1);
    RxD = 1'b1;
    Reset = 1'b0;
    repeat (OS * 8) @(negedge Clock);
    check_out("postrst");
    send_frame(8'hFF, 1'b0, 1'b1);
    check_out("fff");
    check_strobes("fff");
    do_read();

    for (int k = 0; k < 12; k++) begin
      d  = DB'($urandom);
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, sb);
      check_out("rnd");
      check_strobes("rnd");
      if ($urandom_range(0, 1) == 1) begin
        do_read();
        check_out("rnd_rd");
      end
    end

    expect_eq("strobe_overlap", 32'(n_both), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
